// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
package sync_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 64;

  // Pointer carries one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 32'sd1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a FIFO user (master) and sync_fifo_param (slave).
interface sync_fifo_param_if
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = ptr_width(DEF_DEPTH)
);

  logic              wr_en;
  logic [DATA_W-1:0] fifo_in;
  logic              rd_en;
  logic [DATA_W-1:0] fifo_out;
  logic              fifo_full;
  logic              fifo_empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, fifo_in, rd_en,
    input  fifo_out, fifo_full, fifo_empty, almost_full, almost_empty,
           fifo_count, overflow, underflow
  );

  modport slave (
    input  wr_en, fifo_in, rd_en,
    output fifo_out, fifo_full, fifo_empty, almost_full, almost_empty,
           fifo_count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ram.sv
// Simple dual-port register file: synchronous write, asynchronous read, contents never reset.
module fifo_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_r [DEPTH];

  // Storage write port
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised single-clock FIFO with registered status flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle read.
module sync_fifo_param
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 32'sd4,
  parameter int AE_LEVEL = 32'sd4
) (
  input  logic             clk,
  input  logic             rst,
  sync_fifo_param_if.slave bus
);

  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int ADDR_W = PTR_W - 32'sd1;
  localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W-1:0] CNT_ZERO = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0] CNT_FULL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] CNT_AF   = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] CNT_AE   = PTR_W'(AE_LEVEL);

  if ((DEPTH & (DEPTH - 32'sd1)) != 32'sd0 || DEPTH < 32'sd4) begin : g_bad_depth
    $error("sync_fifo_param: DEPTH must be a power of two, at least 4");
  end
  if (AE_LEVEL >= AF_LEVEL) begin : g_bad_levels
    $error("sync_fifo_param: AE_LEVEL must be below AF_LEVEL");
  end

  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r, count_r;
  logic [PTR_W-1:0]  wr_ptr_nxt_s, rd_ptr_nxt_s, count_nxt_s;
  logic              full_r, empty_r, af_r, ae_r, ovf_r, unf_r;
  logic              wr_acc_s, rd_acc_s;
  logic [DATA_W-1:0] ram_rd_s;

  fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_acc_s),
    .wr_addr (wr_ptr_r[ADDR_W-1:0]),
    .wr_data (bus.fifo_in),
    .rd_addr (rd_ptr_r[ADDR_W-1:0]),
    .rd_data (ram_rd_s)
  );

  // Accept decisions use the flags registered before this edge.
  always_comb begin
    wr_acc_s     = bus.wr_en & ~full_r;
    rd_acc_s     = bus.rd_en & ~empty_r;
    wr_ptr_nxt_s = wr_ptr_r;
    rd_ptr_nxt_s = rd_ptr_r;
    if (wr_acc_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
    if (rd_acc_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
    // Modulo-2*DEPTH difference yields 0..DEPTH across wraps.
    count_nxt_s = wr_ptr_nxt_s - rd_ptr_nxt_s;
  end

  // Pointers, occupancy and status flags, all derived from next-state occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {PTR_W{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      af_r     <= 1'b0;
      ae_r     <= 1'b1;
      ovf_r    <= 1'b0;
      unf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nxt_s;
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == CNT_FULL);
      empty_r  <= (count_nxt_s == CNT_ZERO);
      af_r     <= (count_nxt_s >= CNT_AF);
      ae_r     <= (count_nxt_s <= CNT_AE);
      ovf_r    <= bus.wr_en & full_r;
      unf_r    <= bus.rd_en & empty_r;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head word falls through; forced to zero while empty so reset shows 0.
  assign bus.fifo_out = empty_r ? {DATA_W{1'b0}} : ram_rd_s;
`else
  logic [DATA_W-1:0] dout_r;

  // Registered read data, updated only on an accepted read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout_r <= {DATA_W{1'b0}};
    end else if (rd_acc_s) begin
      dout_r <= ram_rd_s;
    end else begin
      dout_r <= dout_r;
    end
  end

  assign bus.fifo_out = dout_r;
`endif

  assign bus.fifo_full    = full_r;
  assign bus.fifo_empty   = empty_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.fifo_count   = count_r;
  assign bus.overflow     = ovf_r;
  assign bus.underflow    = unf_r;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param at default parameters (both read modes).
module tb_sync_fifo_param;
  import sync_fifo_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 64;
  localparam int CNT_W  = ptr_width(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [DATA_W-1:0] sb[$];

  sync_fifo_param_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  sync_fifo_param #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (60),
    .AE_LEVEL (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One clock with the given requests; outputs are sampled 1 ns after the edge.
  task automatic cycle(input logic w, input logic [DATA_W-1:0] d, input logic r);
    bus.wr_en   = w;
    bus.fifo_in = d;
    bus.rd_en   = r;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  // Read cycle returning the word delivered by that read in the current mode.
  task automatic rd_cycle(input logic w, input logic [DATA_W-1:0] d, output logic [DATA_W-1:0] q);
`ifdef SYNC_FIFO_FWFT_EN
    q = bus.fifo_out;
    cycle(w, d, 1'b1);
`else
    cycle(w, d, 1'b1);
    q = bus.fifo_out;
`endif
  endtask

  task automatic test_reset;
    logic [CNT_W+14:0] got;
    rst = 1'b1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.fifo_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    got = {bus.fifo_count, bus.fifo_empty, bus.almost_empty, bus.fifo_full,
           bus.almost_full, bus.overflow, bus.underflow, bus.fifo_out};
    checks++;
    if (got !== {7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL reset_state: got %h expected %h", got,
                         {7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fill_overflow;
    for (int i = 1; i <= 64; i++) begin
      cycle(1'b1, 8'(i), 1'b0);
      checks++;
      if (bus.fifo_count !== 7'(i)) begin
        errors++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, bus.fifo_count, i);
      end
      checks++;
      if (bus.almost_full !== (i >= 60)) begin
        errors++; $display("FAIL fill_almost_full[%0d]: got %b expected %b", i, bus.almost_full, (i >= 60));
      end
      checks++;
      if (bus.almost_empty !== (i <= 4)) begin
        errors++; $display("FAIL fill_almost_empty[%0d]: got %b expected %b", i, bus.almost_empty, (i <= 4));
      end
      checks++;
      if (bus.fifo_full !== (i == 64)) begin
        errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, bus.fifo_full, (i == 64));
      end
    end
    cycle(1'b1, 8'hEE, 1'b0);
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++; $display("FAIL overflow_pulse: got %b expected 1", bus.overflow);
    end
    checks++;
    if (bus.fifo_count !== 7'd64) begin
      errors++; $display("FAIL overflow_count: got %0d expected 64", bus.fifo_count);
    end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (bus.overflow !== 1'b0) begin
      errors++; $display("FAIL overflow_one_cycle: got %b expected 0", bus.overflow);
    end
  endtask

  task automatic test_drain_underflow;
    logic [DATA_W-1:0] q;
    for (int i = 1; i <= 64; i++) begin
      rd_cycle(1'b0, 8'h00, q);
      checks++;
      if (q !== 8'(i)) begin
        errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, q, 8'(i));
      end
      checks++;
      if (bus.fifo_count !== 7'(64 - i)) begin
        errors++; $display("FAIL drain_count[%0d]: got %0d expected %0d", i, bus.fifo_count, 64 - i);
      end
      checks++;
      if (bus.almost_empty !== ((64 - i) <= 4)) begin
        errors++; $display("FAIL drain_almost_empty[%0d]: got %b expected %b", i, bus.almost_empty, ((64 - i) <= 4));
      end
    end
    checks++;
    if (bus.fifo_empty !== 1'b1) begin
      errors++; $display("FAIL drain_empty: got %b expected 1", bus.fifo_empty);
    end
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (bus.underflow !== 1'b1) begin
      errors++; $display("FAIL underflow_pulse: got %b expected 1", bus.underflow);
    end
`ifndef SYNC_FIFO_FWFT_EN
    checks++;
    if (bus.fifo_out !== 8'h40) begin
      errors++; $display("FAIL underflow_hold_out: got %h expected 40", bus.fifo_out);
    end
`endif
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (bus.underflow !== 1'b0) begin
      errors++; $display("FAIL underflow_one_cycle: got %b expected 0", bus.underflow);
    end
  endtask

  task automatic test_simul_empty;
    cycle(1'b1, 8'h80, 1'b1);
    checks++;
    if (bus.fifo_count !== 7'd1) begin
      errors++; $display("FAIL both_empty_count: got %0d expected 1", bus.fifo_count);
    end
    checks++;
    if (bus.underflow !== 1'b1) begin
      errors++; $display("FAIL both_empty_underflow: got %b expected 1", bus.underflow);
    end
`ifdef SYNC_FIFO_FWFT_EN
    checks++;
    if (bus.fifo_out !== 8'h80) begin
      errors++; $display("FAIL both_empty_out: got %h expected 80", bus.fifo_out);
    end
`else
    checks++;
    if (bus.fifo_out !== 8'h40) begin
      errors++; $display("FAIL both_empty_out: got %h expected 40", bus.fifo_out);
    end
`endif
  endtask

  task automatic test_simul_full;
    logic [DATA_W-1:0] q;
    for (int k = 1; k < 64; k++) begin
      cycle(1'b1, 8'(8'h80 + k), 1'b0);
    end
    checks++;
    if (bus.fifo_full !== 1'b1 || bus.fifo_count !== 7'd64) begin
      errors++; $display("FAIL both_full_pre: got full=%b count=%0d expected full=1 count=64",
                         bus.fifo_full, bus.fifo_count);
    end
    rd_cycle(1'b1, 8'hCC, q);
    checks++;
    if (q !== 8'h80) begin
      errors++; $display("FAIL both_full_data: got %h expected 80", q);
    end
    checks++;
    if (bus.fifo_count !== 7'd63) begin
      errors++; $display("FAIL both_full_count: got %0d expected 63", bus.fifo_count);
    end
    checks++;
    if (bus.overflow !== 1'b1) begin
      errors++; $display("FAIL both_full_overflow: got %b expected 1", bus.overflow);
    end
    for (int k = 1; k < 64; k++) begin
      rd_cycle(1'b0, 8'h00, q);
      checks++;
      if (q !== 8'(8'h80 + k)) begin
        errors++; $display("FAIL both_full_drain[%0d]: got %h expected %h", k, q, 8'(8'h80 + k));
      end
    end
    checks++;
    if (bus.fifo_empty !== 1'b1) begin
      errors++; $display("FAIL both_full_end_empty: got %b expected 1", bus.fifo_empty);
    end
  endtask

  task automatic test_wrap;
    logic [DATA_W-1:0] q, exp, wdata;
    logic w, r;
    int nwr, n;
    wdata = 8'h00;
    nwr = 0;
    n = 0;
    sb.delete();
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, wdata, 1'b0);
      sb.push_back(wdata); wdata++;
    end
    while (nwr < 200 && n < 2000) begin
      if (sb.size() <= 10) begin
        w = 1'b1; r = 1'b0;
      end else if (sb.size() >= 50) begin
        w = 1'b0; r = 1'b1;
      end else begin
        w = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
      end
      if (r) begin
        exp = sb.pop_front();
        rd_cycle(w, wdata, q);
        checks++;
        if (q !== exp) begin
          errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", n, q, exp);
        end
      end else begin
        cycle(w, wdata, 1'b0);
      end
      if (w) begin
        sb.push_back(wdata); wdata++; nwr++;
      end
      checks++;
      if (bus.fifo_count !== 7'(sb.size())) begin
        errors++; $display("FAIL wrap_count[%0d]: got %0d expected %0d", n, bus.fifo_count, sb.size());
      end
      n++;
    end
    checks++;
    if (nwr < 200) begin
      errors++; $display("FAIL wrap_budget: got %0d writes expected 200", nwr);
    end
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      rd_cycle(1'b0, 8'h00, q);
      checks++;
      if (q !== exp) begin
        errors++; $display("FAIL wrap_tail: got %h expected %h", q, exp);
      end
    end
    checks++;
    if (bus.fifo_empty !== 1'b1) begin
      errors++; $display("FAIL wrap_end_empty: got %b expected 1", bus.fifo_empty);
    end
  endtask

  task automatic test_async_reset;
    logic [CNT_W+14:0] got;
    logic [DATA_W-1:0] q;
    for (int i = 0; i < 19; i++) begin
      cycle(1'b1, 8'(8'h10 + i), 1'b0);
    end
    bus.wr_en = 1'b1; bus.fifo_in = 8'h23;
    @(posedge clk);
    #1;
    bus.fifo_in = 8'h24;
    checks++;
    if (bus.fifo_count !== 7'd20) begin
      errors++; $display("FAIL areset_pre_count: got %0d expected 20", bus.fifo_count);
    end
    #1 rst = 1'b1;
    #2;
    got = {bus.fifo_count, bus.fifo_empty, bus.almost_empty, bus.fifo_full,
           bus.almost_full, bus.overflow, bus.underflow, bus.fifo_out};
    checks++;
    if (got !== {7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL areset_state: got %h expected %h", got,
                         {7'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00});
    end
    #1 rst = 1'b0;
    bus.wr_en = 1'b0;
    sb.delete();
    cycle(1'b1, 8'h5A, 1'b0);
    checks++;
    if (bus.fifo_count !== 7'd1) begin
      errors++; $display("FAIL areset_first_count: got %0d expected 1", bus.fifo_count);
    end
    rd_cycle(1'b0, 8'h00, q);
    checks++;
    if (q !== 8'h5A) begin
      errors++; $display("FAIL areset_first_data: got %h expected 5a", q);
    end
  endtask

`ifdef SYNC_FIFO_FWFT_EN
  task automatic test_fwft;
    logic [DATA_W-1:0] q;
    cycle(1'b1, 8'hA5, 1'b0);
    checks++;
    if (bus.fifo_out !== 8'hA5 || bus.fifo_empty !== 1'b0) begin
      errors++; $display("FAIL fwft_fall_through: got out=%h empty=%b expected out=a5 empty=0",
                         bus.fifo_out, bus.fifo_empty);
    end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (bus.fifo_out !== 8'hA5) begin
      errors++; $display("FAIL fwft_hold: got %h expected a5", bus.fifo_out);
    end
    rd_cycle(1'b0, 8'h00, q);
    checks++;
    if (q !== 8'hA5 || bus.fifo_empty !== 1'b1) begin
      errors++; $display("FAIL fwft_pop: got q=%h empty=%b expected q=a5 empty=1", q, bus.fifo_empty);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill_overflow();
    test_drain_underflow();
    test_simul_empty();
    test_simul_full();
    test_wrap();
    test_async_reset();
`ifdef SYNC_FIFO_FWFT_EN
    test_fwft();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
